bus_arbiter_mux: RTL and testbench
==================================

Name: bus_arbiter_mux

Overview:
- Parametrised, registered successor to the datapath bus multiplexer.
- Takes NSRC one-hot "out" enables (R0out..R15out, HIout, LOout, Zhighout, Zlowout, PCout, MDRout, InPortout, Cout, ...) plus NSRC packed data words.
- Priority-encodes the enables and drives a registered WIDTH-bit bus.
- Adds bus-keeper hold, multi-driver conflict detection with a saturating counter, and a freeze control for stalls.

Parameters:
- WIDTH, 32, data width of every source and of the bus.
- NSRC, 24, number of bus sources; legal range 2..64.
- SELW, 5, width of bus_sel; must satisfy 2**SELW >= NSRC.
- CNTW, 8, width of conflict_cnt.

Ports:
- clock  in  1  rising-edge system clock.
- clear  in  1  asynchronous, active-high reset.
- src_data  in  NSRC*WIDTH  packed source words; source i occupies bits [i*WIDTH +: WIDTH].
- src_out  in  NSRC  per-source drive enables; source i is the i-th bit.
- freeze  in  1  when high, all bus state holds.
- clr_err  in  1  synchronous clear of sticky_err and conflict_cnt.
- bus_out  out  WIDTH  registered bus value.
- bus_sel  out  SELW  registered index of the source that drove bus_out.
- bus_valid  out  1  registered; high when bus_out was loaded from a source in the previous cycle.
- conflict  out  1  registered one-cycle pulse: more than one enable was seen.
- sticky_err  out  1  latched conflict flag.
- conflict_cnt  out  CNTW  saturating count of conflict cycles.
- bus_parity  out  1  even parity of bus_out (see Optional Feature).

Behaviour:
- Reset (clear=1, asynchronous):
  - bus_out=0, bus_sel=0, bus_valid=0, conflict=0, sticky_err=0, conflict_cnt=0, bus_parity=0.
  - Outputs hold these values for as long as clear is asserted, including mid-transfer.
- Latency: exactly 1 cycle. Enables sampled at edge N appear on bus_out after edge N.
- Selection:
  - Combinational priority encode of src_out; the lowest set index wins.
  - sel_next = that index; data_next = src_data slice at sel_next.
- Per rising edge, when freeze=0:
  - Any src_out bit set: bus_out<=data_next, bus_sel<=sel_next, bus_valid<=1.
  - src_out all zero (bus keeper): bus_out and bus_sel hold; bus_valid<=0.
  - popcount(src_out)>=2:
    - conflict<=1 and sticky_err<=1.
    - conflict_cnt increments, saturating at 2**CNTW-1; no wrap-around.
    - The winner is still the lowest index.
  - Otherwise conflict<=0.
- freeze=1:
  - bus_out, bus_sel, bus_valid, conflict_cnt and sticky_err hold; conflict<=0.
  - Enables are ignored, and conflicts during freeze are not counted.
- clr_err=1 (regardless of freeze):
  - sticky_err<=0 and conflict_cnt<=0.
  - Takes priority over a same-cycle conflict increment.
  - The conflict pulse itself still fires for that cycle.
- Out-of-range indices: src_out bits at or above NSRC do not exist, and bus_sel never exceeds NSRC-1.
- Structure: no combinational path from any input to any output; all outputs come straight from flops.

Optional Feature:
- Macro: BUS_PARITY_EN.
- Defined:
  - bus_parity is registered alongside bus_out and equals the XOR-reduction of the value loaded into bus_out.
  - It holds under keeper and freeze exactly as bus_out does.
- Undefined: bus_parity is tied to constant 0 and no parity logic is generated. The port exists in both builds.

Test Plan:
- Reset: assert clear mid-transfer with src_out[3]=1 and src_data[3]=32'hDEADBEEF. All outputs go to 0 immediately, with no clock edge needed.
- Single driver: src_out=1<<19, src_data[19]=32'h0000_1234. After one edge, bus_out=32'h1234, bus_sel=19, bus_valid=1, conflict=0.
- Keeper: follow the previous case with src_out=0 for 3 cycles. bus_out stays 32'h1234, bus_sel stays 19, bus_valid=0.
- Conflict priority:
  - src_out bits 2 and 7 set, src_data[2]=5, src_data[7]=9. Result: bus_out=5, bus_sel=2, conflict pulses 1 cycle, sticky_err=1, conflict_cnt=1.
  - Repeat 300 conflict cycles: conflict_cnt saturates at 255.
- Freeze and clr_err:
  - freeze=1 with src_out bits 0 and 1 set: bus_out unchanged, conflict=0, count unchanged.
  - Then clr_err=1 together with a live conflict: cnt=0, sticky_err=0, conflict=1.
- Parity (BUS_PARITY_EN defined): load 32'h0000_0007 and bus_parity=1; load 32'h0000_0003 and bus_parity=0. With the macro undefined, bus_parity=0 always.

Source files
------------

// File: rtl/bus_arbiter_mux_if.sv
// Handshake/bus bundle for bus_arbiter_mux: source words, enables, controls and the registered bus.
interface bus_arbiter_mux_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NSRC  = 24,
  parameter int unsigned SELW  = 5,
  parameter int unsigned CNTW  = 8
);
  logic [NSRC*WIDTH-1:0] src_data;
  logic [NSRC-1:0]       src_out;
  logic                  freeze;
  logic                  clr_err;
  logic [WIDTH-1:0]      bus_out;
  logic [SELW-1:0]       bus_sel;
  logic                  bus_valid;
  logic                  conflict;
  logic                  sticky_err;
  logic [CNTW-1:0]       conflict_cnt;
  logic                  bus_parity;

  modport master (
    output src_data, src_out, freeze, clr_err,
    input  bus_out, bus_sel, bus_valid, conflict, sticky_err, conflict_cnt, bus_parity
  );

  modport slave (
    input  src_data, src_out, freeze, clr_err,
    output bus_out, bus_sel, bus_valid, conflict, sticky_err, conflict_cnt, bus_parity
  );
endinterface

// File: rtl/bus_arbiter_mux.sv
// Registered priority bus multiplexer with bus keeper, conflict detection and freeze.
// Optional BUS_PARITY_EN macro adds a registered even-parity output alongside bus_out.
module bus_arbiter_mux #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NSRC  = 24,
  parameter int unsigned SELW  = 5,
  parameter int unsigned CNTW  = 8
) (
  input logic               clock,
  input logic               clear,
  bus_arbiter_mux_if.slave  bus
);

  logic [SELW-1:0]  sel_next;
  logic [WIDTH-1:0] data_next;
  logic             any_en;
  logic             multi_en;

  logic [WIDTH-1:0] bus_q;
  logic [SELW-1:0]  sel_q;
  logic             valid_q;
  logic             conflict_q;
  logic             sticky_q;
  logic [CNTW-1:0]  cnt_q;

  // Lowest set enable wins; scanning downward lets the lowest index overwrite last.
  always_comb begin
    sel_next  = '0;
    data_next = '0;
    for (int i = int'(NSRC) - 1; i >= 0; i--) begin
      if (bus.src_out[i]) begin
        sel_next  = SELW'(i);
        data_next = bus.src_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Clearing the lowest set bit leaves something only when two or more enables are set.
  assign any_en   = |bus.src_out;
  assign multi_en = |(bus.src_out & (bus.src_out - NSRC'(1)));

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      bus_q      <= '0;
      sel_q      <= '0;
      valid_q    <= 1'b0;
      conflict_q <= 1'b0;
      sticky_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      conflict_q <= 1'b0;
      if (!bus.freeze) begin
        if (any_en) begin
          bus_q   <= data_next;
          sel_q   <= sel_next;
          valid_q <= 1'b1;
        end else begin
          valid_q <= 1'b0;
        end
        if (multi_en) conflict_q <= 1'b1;
      end
      // Error clear beats a same-cycle increment; the pulse above is unaffected.
      if (bus.clr_err) begin
        sticky_q <= 1'b0;
        cnt_q    <= '0;
      end else if (!bus.freeze && multi_en) begin
        sticky_q <= 1'b1;
        if (cnt_q != {CNTW{1'b1}}) cnt_q <= cnt_q + CNTW'(1);
      end
    end
  end

`ifdef BUS_PARITY_EN
  logic parity_q;

  // Parity tracks exactly what is loaded into bus_q, so it holds whenever bus_q holds.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      parity_q <= 1'b0;
    end else if (!bus.freeze && any_en) begin
      parity_q <= ^data_next;
    end
  end

  assign bus.bus_parity = parity_q;
`else
  assign bus.bus_parity = 1'b0;
`endif

  assign bus.bus_out      = bus_q;
  assign bus.bus_sel      = sel_q;
  assign bus.bus_valid    = valid_q;
  assign bus.conflict     = conflict_q;
  assign bus.sticky_err   = sticky_q;
  assign bus.conflict_cnt = cnt_q;

endmodule

// File: tb/tb_bus_arbiter_mux.sv
// Directed self-checking bench for bus_arbiter_mux with hand-computed expectations.
module tb_bus_arbiter_mux;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned NSRC  = 24;
  localparam int unsigned SELW  = 5;
  localparam int unsigned CNTW  = 8;
`ifdef BUS_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic clock;
  logic clear;
  int   checks;
  int   errors;

  bus_arbiter_mux_if #(.WIDTH(WIDTH), .NSRC(NSRC), .SELW(SELW), .CNTW(CNTW)) bif ();

  bus_arbiter_mux #(.WIDTH(WIDTH), .NSRC(NSRC), .SELW(SELW), .CNTW(CNTW)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bif)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_src(input int idx, input logic [WIDTH-1:0] d);
    bif.src_data[idx*WIDTH +: WIDTH] = d;
  endtask

  // Advance one edge and sample 1 time unit later.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_bus(input string tag, input logic [31:0] b, input int s, input bit v,
                           input bit c, input bit st, input int cnt);
    check({tag, ".bus_out"},      64'(bif.bus_out),      64'(b));
    check({tag, ".bus_sel"},      64'(bif.bus_sel),      64'(s));
    check({tag, ".bus_valid"},    64'(bif.bus_valid),    64'(v));
    check({tag, ".conflict"},     64'(bif.conflict),     64'(c));
    check({tag, ".sticky_err"},   64'(bif.sticky_err),   64'(st));
    check({tag, ".conflict_cnt"}, 64'(bif.conflict_cnt), 64'(cnt));
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    clear        = 1'b1;
    bif.src_data = '0;
    bif.src_out  = '0;
    bif.freeze   = 1'b0;
    bif.clr_err  = 1'b0;
    #12;
    check_bus("reset", 32'h0, 0, 1'b0, 1'b0, 1'b0, 0);
    check("reset.parity", 64'(bif.bus_parity), 64'(0));
    @(negedge clock);
    clear = 1'b0;

    // Single driver at index 19; 0x1234 has five ones.
    set_src(19, 32'h0000_1234);
    bif.src_out = 24'(1) << 19;
    step();
    check_bus("single", 32'h1234, 19, 1'b1, 1'b0, 1'b0, 0);
    check("single.parity", 64'(bif.bus_parity), 64'(PAR_EN));

    // Bus keeper holds value/select, valid drops.
    bif.src_out = '0;
    for (int k = 0; k < 3; k++) begin
      step();
      check_bus($sformatf("keeper%0d", k), 32'h1234, 19, 1'b0, 1'b0, 1'b0, 0);
    end

    // Asynchronous clear mid-transfer, no edge required.
    set_src(3, 32'hDEAD_BEEF);
    bif.src_out = 24'(1) << 3;
    step();
    check("xfer.bus_out", 64'(bif.bus_out), 64'(32'hDEAD_BEEF));
    #2;
    clear = 1'b1;
    #1;
    check_bus("async_clr", 32'h0, 0, 1'b0, 1'b0, 1'b0, 0);
    check("async_clr.parity", 64'(bif.bus_parity), 64'(0));
    step();
    check_bus("clr_held", 32'h0, 0, 1'b0, 1'b0, 1'b0, 0);
    @(negedge clock);
    clear       = 1'b0;
    bif.src_out = '0;

    // Conflict on bits 2 and 7: lowest index wins.
    set_src(2, 32'd5);
    set_src(7, 32'd9);
    bif.src_out = (24'(1) << 2) | (24'(1) << 7);
    step();
    check_bus("conflict", 32'd5, 2, 1'b1, 1'b1, 1'b1, 1);
    bif.src_out = '0;
    step();
    check_bus("conflict_end", 32'd5, 2, 1'b0, 1'b0, 1'b1, 1);

    // 300 more conflicts saturate the counter at 255.
    bif.src_out = (24'(1) << 2) | (24'(1) << 7);
    for (int k = 0; k < 300; k++) step();
    check_bus("saturate", 32'd5, 2, 1'b1, 1'b1, 1'b1, 255);

    // Freeze ignores enables and does not count the conflict.
    set_src(0, 32'h0000_00AA);
    set_src(1, 32'h0000_00BB);
    bif.freeze  = 1'b1;
    bif.src_out = 24'h3;
    step();
    check_bus("freeze", 32'd5, 2, 1'b1, 1'b0, 1'b1, 255);

    // clr_err beats a live conflict increment; pulse still fires.
    bif.freeze  = 1'b0;
    bif.clr_err = 1'b1;
    step();
    check_bus("clr_err", 32'hAA, 0, 1'b1, 1'b1, 1'b0, 0);
    bif.clr_err = 1'b0;
    step();
    check_bus("recount", 32'hAA, 0, 1'b1, 1'b1, 1'b1, 1);

    // clr_err also acts while frozen.
    bif.freeze  = 1'b1;
    bif.clr_err = 1'b1;
    step();
    check_bus("clr_frozen", 32'hAA, 0, 1'b1, 1'b0, 1'b0, 0);
    bif.freeze  = 1'b0;
    bif.clr_err = 1'b0;

    // Parity, using the top source index as the boundary case.
    set_src(23, 32'h0000_0007);
    bif.src_out = 24'(1) << 23;
    step();
    check_bus("par7", 32'h7, 23, 1'b1, 1'b0, 1'b0, 0);
    check("par7.parity", 64'(bif.bus_parity), 64'(PAR_EN));
    set_src(23, 32'h0000_0003);
    step();
    check("par3.bus_out", 64'(bif.bus_out), 64'(32'h3));
    check("par3.parity", 64'(bif.bus_parity), 64'(0));
    // Parity holds under freeze even when a new odd word is offered.
    set_src(23, 32'h0000_0001);
    bif.freeze = 1'b1;
    step();
    check("par_freeze.bus_out", 64'(bif.bus_out), 64'(32'h3));
    check("par_freeze.parity", 64'(bif.bus_parity), 64'(0));
    bif.freeze = 1'b0;
    step();
    check("par1.bus_out", 64'(bif.bus_out), 64'(32'h1));
    check("par1.parity", 64'(bif.bus_parity), 64'(PAR_EN));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
